// File: rtl/miner_dma_pkg.sv
// Shared types and constants for the miner DMA operator.
package miner_dma_pkg;

  localparam int          HEADER_WORDS_DEF = 20;
  localparam logic [15:0] RESULT_MAGIC     = 16'h4D52;

  typedef enum logic [2:0] {
    ST_RX    = 3'd0,
    ST_DRAIN = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_TX0   = 3'd4,
    ST_TX1   = 3'd5
  } state_e;

  typedef struct packed {
    logic [15:0] magic;
    logic [6:0]  pad;
    logic        found;
    logic [7:0]  id;
  } res_word0_t;

  // First beat of the result packet: magic tag, found flag and job tag.
  function automatic logic [31:0] pack_word0(input logic found, input logic [7:0] id);
    res_word0_t w;
    w.magic = RESULT_MAGIC;
    w.pad   = 7'd0;
    w.found = found;
    w.id    = id;
    return w;
  endfunction

endpackage

// File: rtl/miner_header_assembler.sv
// Collects header beats into a flat register and judges the framing of each frame.
module miner_header_assembler
  import miner_dma_pkg::*;
#(
  parameter int HEADER_WORDS = HEADER_WORDS_DEF
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      i_beat,
  input  logic [31:0]               i_tdata,
  input  logic [3:0]                i_tkeep,
  input  logic                      i_tlast,
  output logic [32*HEADER_WORDS-1:0] o_header,
  output logic                      o_frame_ok,
  output logic                      o_frame_err,
  output logic                      o_overrun
);

  localparam int CNT_W = $clog2(HEADER_WORDS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(HEADER_WORDS - 1);

  logic [CNT_W-1:0]          r_cnt;
  logic                      r_bad;
  logic [32*HEADER_WORDS-1:0] r_header;
  logic                      w_bad_nxt;
  logic                      w_at_last;

  // Framing verdict for the beat being accepted this cycle.
  always_comb begin
    w_bad_nxt   = r_bad | (i_tkeep != 4'hF);
    w_at_last   = (r_cnt == LAST_IDX);
    o_frame_ok  = i_beat & w_at_last & i_tlast & ~w_bad_nxt;
    o_frame_err = i_beat & i_tlast & (~w_at_last | w_bad_nxt);
    o_overrun   = i_beat & w_at_last & ~i_tlast;
  end

  // Store each beat at its word slot; any frame end or full header restarts the count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt    <= '0;
      r_bad    <= 1'b0;
      r_header <= '0;
    end else if (i_beat) begin
      for (int k = 0; k < HEADER_WORDS; k++) begin
        if (r_cnt == CNT_W'(k)) begin
          r_header[k*32 +: 32] <= i_tdata;
        end
      end
      if (i_tlast || w_at_last) begin
        r_cnt <= '0;
        r_bad <= 1'b0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
        r_bad <= w_bad_nxt;
      end
    end
  end

  assign o_header = r_header;

endmodule

// File: rtl/miner_dma_operator.sv
// Receives a block header frame, issues it as one job, and streams back the hasher result.
module miner_dma_operator
  import miner_dma_pkg::*;
#(
  parameter int HEADER_WORDS = HEADER_WORDS_DEF,
  parameter int ERR_W        = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [31:0]                s_tdata,
  input  logic [3:0]                 s_tkeep,
  input  logic                       s_tlast,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  output logic [31:0]                m_tdata,
  output logic [3:0]                 m_tkeep,
  output logic                       m_tlast,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic [32*HEADER_WORDS-1:0] job_header,
  output logic [7:0]                 job_id,
  output logic                       job_valid,
  input  logic                       job_ready,
  input  logic                       res_found,
  input  logic [31:0]                res_nonce,
  input  logic                       res_valid,
  output logic                       res_ready,
  output logic                       busy,
  output logic [ERR_W-1:0]           err_count
);

  state_e           r_state, w_state_nxt;
  logic             r_s_tready, r_m_tvalid, r_m_tlast, r_job_valid, r_res_ready, r_busy;
  logic [31:0]      r_m_tdata, r_nonce, w_tdata_nxt, w_nonce_nxt;
  logic [3:0]       r_m_tkeep;
  logic [ERR_W-1:0] r_err_count;
  logic [7:0]       r_job_id, r_cur_id;
  logic             r_found, w_found_nxt;
  logic             w_s_fire, w_job_fire, w_res_fire, w_m_fire, w_beat, w_drain_end, w_err_inc;
  logic             w_frame_ok, w_frame_err, w_overrun;

  assign w_s_fire    = s_tvalid & r_s_tready;
  assign w_job_fire  = r_job_valid & job_ready;
  assign w_res_fire  = res_valid & r_res_ready;
  assign w_m_fire    = r_m_tvalid & m_tready;
  assign w_beat      = w_s_fire & (r_state == ST_RX);
  assign w_drain_end = w_s_fire & (r_state == ST_DRAIN) & s_tlast;
  assign w_err_inc   = w_frame_err | w_drain_end;

  miner_header_assembler #(.HEADER_WORDS(HEADER_WORDS)) u_asm (
    .clk        (clk),
    .rstn       (rstn),
    .i_beat     (w_beat),
    .i_tdata    (s_tdata),
    .i_tkeep    (s_tkeep),
    .i_tlast    (s_tlast),
    .o_header   (job_header),
    .o_frame_ok (w_frame_ok),
    .o_frame_err(w_frame_err),
    .o_overrun  (w_overrun)
  );

  // Next state from framing verdicts and the job/result/stream handshakes.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RX: begin
        if (w_frame_ok) begin
          w_state_nxt = ST_ISSUE;
        end else if (w_overrun) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_RX;
        end
      end
      ST_DRAIN: w_state_nxt = w_drain_end ? ST_RX   : ST_DRAIN;
      ST_ISSUE: w_state_nxt = w_job_fire  ? ST_WAIT : ST_ISSUE;
      ST_WAIT:  w_state_nxt = w_res_fire  ? ST_TX0  : ST_WAIT;
      ST_TX0:   w_state_nxt = w_m_fire    ? ST_TX1  : ST_TX0;
      ST_TX1:   w_state_nxt = w_m_fire    ? ST_RX   : ST_TX1;
      default:  w_state_nxt = ST_RX;
    endcase
  end

  // Result beat contents for the upcoming state, so the registered data is held under back-pressure.
  always_comb begin
    w_found_nxt = w_res_fire ? res_found : r_found;
    w_nonce_nxt = w_res_fire ? res_nonce : r_nonce;
    w_tdata_nxt = 32'h0;
    case (w_state_nxt)
      ST_TX0:  w_tdata_nxt = pack_word0(w_found_nxt, r_cur_id);
      ST_TX1:  w_tdata_nxt = w_found_nxt ? w_nonce_nxt : 32'h0;
      default: w_tdata_nxt = 32'h0;
    endcase
  end

  // State, registered outputs, job tag, captured result and saturating error count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_RX;
      r_s_tready  <= 1'b0;
      r_m_tvalid  <= 1'b0;
      r_m_tlast   <= 1'b0;
      r_m_tdata   <= 32'h0;
      r_m_tkeep   <= 4'h0;
      r_job_valid <= 1'b0;
      r_res_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_err_count <= '0;
      r_job_id    <= 8'd0;
      r_cur_id    <= 8'd0;
      r_found     <= 1'b0;
      r_nonce     <= 32'h0;
    end else begin
      r_state     <= w_state_nxt;
      r_s_tready  <= (w_state_nxt == ST_RX) || (w_state_nxt == ST_DRAIN);
      r_busy      <= (w_state_nxt != ST_RX);
      r_job_valid <= (w_state_nxt == ST_ISSUE);
      r_res_ready <= (w_state_nxt == ST_WAIT);
      r_m_tvalid  <= (w_state_nxt == ST_TX0) || (w_state_nxt == ST_TX1);
      r_m_tlast   <= (w_state_nxt == ST_TX1);
      r_m_tkeep   <= ((w_state_nxt == ST_TX0) || (w_state_nxt == ST_TX1)) ? 4'hF : 4'h0;
      r_m_tdata   <= w_tdata_nxt;
      r_found     <= w_found_nxt;
      r_nonce     <= w_nonce_nxt;
      if (w_job_fire) begin
        r_cur_id <= r_job_id;
        r_job_id <= r_job_id + 8'd1;
      end
      if (w_err_inc && (r_err_count != {ERR_W{1'b1}})) begin
        r_err_count <= r_err_count + ERR_W'(1);
      end
    end
  end

  assign s_tready  = r_s_tready;
  assign m_tvalid  = r_m_tvalid;
  assign m_tlast   = r_m_tlast;
  assign m_tdata   = r_m_tdata;
  assign m_tkeep   = r_m_tkeep;
  assign job_valid = r_job_valid;
  assign job_id    = r_job_id;
  assign res_ready = r_res_ready;
  assign busy      = r_busy;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_miner_dma_operator.sv
// Directed bench for miner_dma_operator: framing, job issue, result packet, back-pressure, wrap, reset.
module tb_miner_dma_operator;

  logic         clk = 1'b0;
  logic         rstn;
  logic [31:0]  s_tdata;
  logic [3:0]   s_tkeep;
  logic         s_tlast, s_tvalid, s_tready;
  logic [31:0]  m_tdata;
  logic [3:0]   m_tkeep;
  logic         m_tlast, m_tvalid, m_tready;
  logic [639:0] job_header;
  logic [7:0]   job_id;
  logic         job_valid, job_ready;
  logic         res_found;
  logic [31:0]  res_nonce;
  logic         res_valid, res_ready, busy;
  logic [15:0]  err_count;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  miner_dma_operator dut (
    .clk(clk), .rstn(rstn),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .job_header(job_header), .job_id(job_id), .job_valid(job_valid), .job_ready(job_ready),
    .res_found(res_found), .res_nonce(res_nonce), .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One beat; waits (bounded) for s_tready, which is stable between edges.
  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int bound;
    s_tvalid = 1'b1; s_tdata = d; s_tkeep = k; s_tlast = l;
    bound = 0;
    while (!s_tready && bound < 100) begin
      tick();
      bound++;
    end
    if (bound >= 100) chk("s_tready_timeout", {31'd0, s_tready}, 32'd1);
    tick();
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic send_frame(input int n, input int last_at, input int bad_at, input logic [31:0] base);
    for (int i = 1; i <= n; i++) begin
      send_beat(base + 32'(i), (i == bad_at) ? 4'h7 : 4'hF, i == last_at);
    end
  endtask

  // Called with job_valid expected high; runs the job through result transmission.
  task automatic finish_job(input logic found, input logic [31:0] nonce, input logic [7:0] id, input int stall);
    logic [31:0] w0, w1;
    logic [7:0]  nid;
    w0  = {16'h4D52, 7'd0, found, id};
    w1  = found ? nonce : 32'h0;
    nid = id + 8'd1;
    chk("job_valid_up", {31'd0, job_valid}, 32'd1);
    chk("job_id_pre", {24'd0, job_id}, {24'd0, id});
    chk("s_tready_issue", {31'd0, s_tready}, 32'd0);
    job_ready = 1'b1;
    tick();
    job_ready = 1'b0;
    chk("job_valid_down", {31'd0, job_valid}, 32'd0);
    chk("job_id_post", {24'd0, job_id}, {24'd0, nid});
    chk("res_ready_wait", {31'd0, res_ready}, 32'd1);
    res_valid = 1'b1; res_found = found; res_nonce = nonce;
    tick();
    res_valid = 1'b0; res_found = 1'b0; res_nonce = 32'h0;
    chk("tx0_valid", {31'd0, m_tvalid}, 32'd1);
    chk("tx0_data", m_tdata, w0);
    chk("tx0_last", {31'd0, m_tlast}, 32'd0);
    chk("tx0_keep", {28'd0, m_tkeep}, 32'hF);
    for (int c = 0; c < stall; c++) begin
      tick();
      chk("tx0_hold", m_tdata, w0);
      chk("tx0_stall_tready", {31'd0, s_tready}, 32'd0);
    end
    m_tready = 1'b1;
    tick();
    chk("tx1_data", m_tdata, w1);
    chk("tx1_last", {31'd0, m_tlast}, 32'd1);
    if (stall > 0) begin
      m_tready = 1'b0;
      for (int c = 0; c < 2; c++) begin
        tick();
        chk("tx1_hold", m_tdata, w1);
        chk("tx1_hold_valid", {31'd0, m_tvalid}, 32'd1);
        chk("tx1_stall_tready", {31'd0, s_tready}, 32'd0);
      end
      m_tready = 1'b1;
      tick();
    end else begin
      tick();
    end
    m_tready = 1'b0;
    chk("tx_done_valid", {31'd0, m_tvalid}, 32'd0);
    chk("back_rx_tready", {31'd0, s_tready}, 32'd1);
    chk("back_rx_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_s_tready"}, {31'd0, s_tready}, 32'd0);
    chk({tag, "_m_tvalid"}, {31'd0, m_tvalid}, 32'd0);
    chk({tag, "_m_tdata"}, m_tdata, 32'd0);
    chk({tag, "_job_valid"}, {31'd0, job_valid}, 32'd0);
    chk({tag, "_job_hdr"}, {31'd0, |job_header}, 32'd0);
    chk({tag, "_job_id"}, {24'd0, job_id}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_err"}, {16'd0, err_count}, 32'd0);
  endtask

  initial begin
    rstn = 1'b0;
    s_tdata = 32'h0; s_tkeep = 4'h0; s_tlast = 1'b0; s_tvalid = 1'b0;
    m_tready = 1'b0; job_ready = 1'b0;
    res_found = 1'b0; res_nonce = 32'h0; res_valid = 1'b0;
    tick(); tick();
    check_all_zero("rst");
    rstn = 1'b1;
    #1;
    chk("tready_before_edge", {31'd0, s_tready}, 32'd0);
    tick();
    chk("tready_after_reset", {31'd0, s_tready}, 32'd1);

    // Nominal frame 1..20, found result.
    send_frame(20, 20, 0, 32'h0);
    chk("hdr_w0", job_header[31:0], 32'h1);
    chk("hdr_w19", job_header[639:608], 32'h14);
    chk("busy_issue", {31'd0, busy}, 32'd1);
    finish_job(1'b1, 32'hDEADBEEF, 8'd0, 0);
    chk("job_id_after_first", {24'd0, job_id}, 32'd1);

    // Short frame then a good one.
    send_frame(5, 5, 0, 32'h100);
    tick();
    chk("short_err", {16'd0, err_count}, 32'd1);
    chk("short_no_job", {31'd0, job_valid}, 32'd0);
    send_frame(20, 20, 0, 32'h200);
    chk("after_short_hdr_w0", job_header[31:0], 32'h201);
    finish_job(1'b1, 32'h12345678, 8'd1, 0);

    // Overlong frame: 20 beats, then 3 drained beats.
    send_frame(21, 0, 0, 32'h300);
    chk("drain_busy", {31'd0, busy}, 32'd1);
    chk("drain_no_job", {31'd0, job_valid}, 32'd0);
    chk("drain_tready", {31'd0, s_tready}, 32'd1);
    send_frame(2, 2, 0, 32'h400);
    tick();
    chk("long_err", {16'd0, err_count}, 32'd2);
    chk("long_no_job", {31'd0, job_valid}, 32'd0);
    chk("long_back_rx", {31'd0, busy}, 32'd0);

    // Bad byte enable on beat 3.
    send_frame(20, 20, 3, 32'h500);
    tick();
    chk("keep_err", {16'd0, err_count}, 32'd3);
    chk("keep_no_job", {31'd0, job_valid}, 32'd0);

    // Not found, with stream back-pressure.
    send_frame(20, 20, 0, 32'h600);
    finish_job(1'b0, 32'hCAFEF00D, 8'd2, 10);

    // 256 jobs so the tag passes 255 -> 0 and returns to 3.
    for (int j = 0; j < 256; j++) begin
      send_frame(20, 20, 0, 32'(j) << 8);
      finish_job(j[0], 32'(j) * 32'h01010101, 8'(3 + j), 0);
      if (8'(3 + j) == 8'hFF) chk("wrap_to_zero", {24'd0, job_id}, 32'd0);
    end
    chk("id_after_256", {24'd0, job_id}, 32'd3);
    chk("err_unchanged", {16'd0, err_count}, 32'd3);

    // Reset in the middle of a frame.
    send_frame(7, 0, 0, 32'h700);
    #2;
    rstn = 1'b0;
    #1;
    check_all_zero("midrst");
    tick();
    rstn = 1'b1;
    tick();
    send_frame(20, 20, 0, 32'h800);
    chk("post_rst_hdr_w0", job_header[31:0], 32'h801);
    finish_job(1'b1, 32'h0BADF00D, 8'd0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
